// File: rtl/top_pkg.sv
// Shared types and defaults for the CSI lane aligner.
package top_pkg;

    localparam int NUM_LANE    = 4;
    localparam int ALIGN_DEPTH = 8;
    localparam int SKEW_TMO    = 16;

    typedef logic [7:0]          lane_data_t;
    typedef logic [NUM_LANE-1:0] lane_vld_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } align_state_t;

endpackage

// File: rtl/csi_lane_fifo.sv
// Per-lane skew buffer: DEPTH bytes, wrap-bit pointers, show-ahead read
// so the aligner can register the head byte in the same cycle it pops.
module csi_lane_fifo
    import top_pkg::*;
#(
    parameter int DEPTH = ALIGN_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  lane_data_t              wr_data,
    input  logic                    rd_en,
    output lane_data_t              rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);

    lane_data_t    mem [DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          rd_ok;
    logic          wr_ok;

    // Pointers carry one extra wrap bit; equal means empty, MSB-only
    // difference means full.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign rd_ok   = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update with synchronous clear taking priority over traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/csi_lane_aligner.sv
// CSI-2 lane deskew: buffers each lane's bytes and releases one word per
// cycle once every enabled lane holds data. Error pulses are registered and
// appear the cycle after the event that caused them.
module csi_lane_aligner #(
    parameter int NUM_LANE = top_pkg::NUM_LANE,
    parameter int DEPTH    = top_pkg::ALIGN_DEPTH,
    parameter int SKEW_TMO = top_pkg::SKEW_TMO
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LANE-1:0]   lane_en,
    input  logic [NUM_LANE-1:0]   in_vld,
    input  logic [NUM_LANE*8-1:0] in_data,
    output logic                  out_vld,
    output logic [NUM_LANE*8-1:0] out_data,
    output logic                  err_skew,
    output logic                  err_ovf,
    output logic                  busy
);

    localparam int CW = $clog2(SKEW_TMO + 1);
    localparam int AW = $clog2(DEPTH);

    top_pkg::align_state_t state_reg;
    top_pkg::align_state_t state_next;
    logic [CW-1:0]         tmo_cnt_reg;
    logic [CW-1:0]         tmo_cnt_next;

    logic [NUM_LANE-1:0]   wr_req;
    logic [NUM_LANE-1:0]   lane_ready;
    logic [NUM_LANE-1:0]   lane_empty;
    logic [NUM_LANE-1:0]   lane_full;
    logic [NUM_LANE-1:0]   lane_ovf;
    logic [NUM_LANE*8-1:0] pop_data;

    logic                  pop;
    logic                  clr;
    logic                  any_vld;
    logic                  all_ready;
    logic                  any_empty;
    logic                  any_ovf;
    logic                  err_skew_next;

    logic                  out_vld_reg;
    logic [NUM_LANE*8-1:0] out_data_reg;
    logic                  err_skew_reg;
    logic                  err_ovf_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
            logic [AW:0]         fifo_count;
            top_pkg::lane_data_t fifo_rd_data;

            // FLUSH refuses input so a bad packet cannot leak into the next.
            assign wr_req[gi] = in_vld[gi] && lane_en[gi] &&
                                (state_reg != top_pkg::ST_FLUSH);

            csi_lane_fifo #(
                .DEPTH(DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .wr_en   (wr_req[gi]),
                .wr_data (in_data[8*gi +: 8]),
                .rd_en   (pop && lane_en[gi]),
                .rd_data (fifo_rd_data),
                .count   (fifo_count),
                .empty   (lane_empty[gi]),
                .full    (lane_full[gi])
            );

            // Disabled lanes never hold back alignment.
            assign lane_ready[gi] = !lane_en[gi] || (fifo_count != '0);
            assign lane_ovf[gi]   = wr_req[gi] && lane_full[gi] && !pop;
            assign pop_data[8*gi +: 8] = lane_en[gi] ? fifo_rd_data : 8'h00;
        end
    endgenerate

    assign any_vld   = |(in_vld & lane_en);
    assign all_ready = (&lane_ready) && (|lane_en);
    assign any_empty = |(lane_empty & lane_en);
    assign any_ovf   = |lane_ovf;

    // Next-state, pop and clear decisions; overflow overrides everything.
    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        pop           = 1'b0;
        clr           = 1'b0;
        err_skew_next = 1'b0;
        case (state_reg)
            top_pkg::ST_IDLE: begin
                if (any_vld) begin
                    state_next   = top_pkg::ST_WAIT;
                    tmo_cnt_next = '0;
                end
            end
            top_pkg::ST_WAIT: begin
                tmo_cnt_next = tmo_cnt_reg + CW'(1);
                if (all_ready) begin
                    pop        = 1'b1;
                    state_next = top_pkg::ST_STREAM;
                end else if (tmo_cnt_reg == CW'(SKEW_TMO - 1)) begin
                    err_skew_next = 1'b1;
                    state_next    = top_pkg::ST_FLUSH;
                end
            end
            top_pkg::ST_STREAM: begin
                if (all_ready) begin
                    pop = 1'b1;
                end else if (!any_vld && any_empty) begin
                    // Packet over: leftover bytes of leading lanes are dropped.
                    clr        = 1'b1;
                    state_next = top_pkg::ST_IDLE;
                end
            end
            top_pkg::ST_FLUSH: begin
                clr = 1'b1;
                if (!(|in_vld)) begin
                    state_next = top_pkg::ST_IDLE;
                end
            end
            default: begin
                state_next = top_pkg::ST_IDLE;
            end
        endcase
        if (any_ovf) begin
            state_next = top_pkg::ST_FLUSH;
        end
    end

    // State and skew timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= top_pkg::ST_IDLE;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    // Output word and error pulse registers; data holds when nothing pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
            err_skew_reg <= 1'b0;
            err_ovf_reg  <= 1'b0;
        end else begin
            out_vld_reg  <= pop;
            err_skew_reg <= err_skew_next;
            err_ovf_reg  <= any_ovf;
            if (pop) begin
                out_data_reg <= pop_data;
            end
        end
    end

    assign out_vld  = out_vld_reg;
    assign out_data = out_data_reg;
    assign err_skew = err_skew_reg;
    assign err_ovf  = err_ovf_reg;
    assign busy     = (state_reg != top_pkg::ST_IDLE);

endmodule

// File: tb/tb_csi_lane_aligner.sv
// Bench for csi_lane_aligner (4 lanes, depth 8, timeout 16): directed
// scenarios plus random skewed packets scored against a per-word timing model.
module tb_csi_lane_aligner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  lane_en;
    logic [3:0]  in_vld;
    logic [31:0] in_data;
    logic        out_vld;
    logic [31:0] out_data;
    logic        err_skew;
    logic        err_ovf;
    logic        busy;

    csi_lane_aligner #(
        .NUM_LANE (4),
        .DEPTH    (8),
        .SKEW_TMO (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lane_en  (lane_en),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_data (out_data),
        .err_skew (err_skew),
        .err_ovf  (err_ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          out_cyc_q[$];
    logic [31:0] out_dat_q[$];
    int          ovf_q[$];
    int          skew_q[$];

    // Record every output event with the cycle it was observed in.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                out_cyc_q.push_back(cyc);
                out_dat_q.push_back(out_data);
            end
            if (err_ovf)  ovf_q.push_back(cyc);
            if (err_skew) skew_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d);
        @(posedge clk);
        #1;
        in_vld  = v;
        in_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'h0, 32'h0);
    endtask

    task automatic clear_q();
        out_cyc_q.delete();
        out_dat_q.delete();
        ovf_q.delete();
        skew_q.delete();
    endtask

    // Single aligned word expected at cycle t_exp with value w_exp.
    task automatic expect_one(input string name, input int t_exp, input logic [31:0] w_exp);
        check({name, "_nwords"}, 32'(out_cyc_q.size()), 32'd1);
        if (out_cyc_q.size() > 0) begin
            check({name, "_cycle"}, 32'(out_cyc_q[0]), 32'(t_exp));
            check({name, "_data"}, out_dat_q[0], w_exp);
        end
        check({name, "_no_err"}, 32'(ovf_q.size() + skew_q.size()), 32'd0);
        $display("txn %s: words=%0d data=%h", name, out_cyc_q.size(),
                 (out_dat_q.size() > 0) ? out_dat_q[0] : 32'h0);
    endtask

    logic [7:0] pkt [4][16];
    int         dly [4];

    // Random packet: per-lane skew 0..3, length 1..12, junk on disabled lanes.
    task automatic rand_txn(input int n);
        logic [3:0]  en;
        logic [3:0]  v;
        logic [31:0] d;
        logic [31:0] w_exp;
        int          len;
        int          dmax;
        int          c0;
        int          wmax;
        int          t_exp [16];
        en   = 4'($urandom_range(1, 15));
        len  = $urandom_range(1, 12);
        dmax = 0;
        for (int i = 0; i < 4; i++) begin
            dly[i] = $urandom_range(0, 3);
            if (en[i] && dly[i] > dmax) dmax = dly[i];
            for (int k = 0; k < 16; k++) pkt[i][k] = 8'($urandom);
        end
        lane_en = en;
        clear_q();
        c0 = 0;
        for (int c = 0; c < dmax + len; c++) begin
            v = 4'h0;
            d = 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    if (c >= dly[i] && c < dly[i] + len) begin
                        v[i] = 1'b1;
                        d[8*i +: 8] = pkt[i][c - dly[i]];
                    end
                end else begin
                    v[i] = 1'($urandom_range(0, 1));
                    d[8*i +: 8] = 8'($urandom);
                end
            end
            drive(v, d);
            if (c == 0) c0 = cyc;
        end
        idle(6);
        // Word k is complete once its latest lane byte is written, appears two
        // cycles later, and words leave at most one per cycle.
        for (int k = 0; k < len; k++) begin
            wmax = 0;
            for (int i = 0; i < 4; i++)
                if (en[i] && c0 + dly[i] + k > wmax) wmax = c0 + dly[i] + k;
            t_exp[k] = wmax + 2;
            if (k > 0 && t_exp[k-1] + 1 > t_exp[k]) t_exp[k] = t_exp[k-1] + 1;
        end
        check("rnd_nwords", 32'(out_cyc_q.size()), 32'(len));
        for (int k = 0; k < len && k < out_cyc_q.size(); k++) begin
            w_exp = 32'h0;
            for (int i = 0; i < 4; i++) if (en[i]) w_exp[8*i +: 8] = pkt[i][k];
            check("rnd_data", out_dat_q[k], w_exp);
            check("rnd_cycle", 32'(out_cyc_q[k]), 32'(t_exp[k]));
        end
        check("rnd_no_err", 32'(ovf_q.size() + skew_q.size()), 32'd0);
        check("rnd_idle", 32'(busy), 32'd0);
        $display("txn rnd%0d: en=%b len=%0d skew=%0d/%0d/%0d/%0d words=%0d",
                 n, en, len, dly[0], dly[1], dly[2], dly[3], out_cyc_q.size());
    endtask

    int t;

    initial begin
        rst_n   = 1'b0;
        lane_en = 4'hF;
        in_vld  = 4'h0;
        in_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_err_skew", 32'(err_skew), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        $display("txn reset: checked reset values");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // All lanes disabled: activity is ignored entirely.
        lane_en = 4'h0;
        clear_q();
        for (int i = 0; i < 6; i++) begin
            drive(4'($urandom), $urandom);
            @(negedge clk);
            check("off_busy", 32'(busy), 32'd0);
        end
        idle(3);
        check("off_nwords", 32'(out_cyc_q.size()), 32'd0);
        check("off_out_data", out_data, 32'h0);
        check("off_no_err", 32'(ovf_q.size() + skew_q.size()), 32'd0);
        $display("txn lanes_off: words=%0d", out_cyc_q.size());

        // Aligned word on all lanes.
        lane_en = 4'hF;
        clear_q();
        drive(4'hF, 32'h13121110);
        t = cyc;
        idle(5);
        expect_one("aligned", t + 2, 32'h13121110);

        // Lanes 2..3 disabled: their bytes never reach the output.
        lane_en = 4'b0011;
        clear_q();
        drive(4'hF, 32'hDEAD6655);
        t = cyc;
        idle(5);
        expect_one("half_en", t + 2, 32'h00006655);

        // Lane 3 silent: skew timeout 16 cycles after entering WAIT.
        lane_en = 4'hF;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0111, {8'h00, 8'($urandom), 8'($urandom), 8'($urandom)});
            if (i == 0) t = cyc;
        end
        @(negedge clk);
        check("skew_busy_wait", 32'(busy), 32'd1);
        idle(22);
        check("skew_npulse", 32'(skew_q.size()), 32'd1);
        if (skew_q.size() > 0) check("skew_cycle", 32'(skew_q[0]), 32'(t + 17));
        check("skew_nwords", 32'(out_cyc_q.size()), 32'd0);
        check("skew_no_ovf", 32'(ovf_q.size()), 32'd0);
        check("skew_idle", 32'(busy), 32'd0);
        $display("txn skew_tmo: pulses=%0d", skew_q.size());

        // Lane 1 late by 9: ninth unpopped write on lane 0 overflows.
        clear_q();
        for (int c = 0; c < 17; c++) begin
            logic [3:0] v;
            v = 4'h0;
            if (c < 12) v = v | 4'b1101;
            if (c >= 9) v = v | 4'b0010;
            drive(v, $urandom);
            if (c == 0) t = cyc;
            if (c == 10) check("ovf_busy_flush", 32'(busy), 32'd1);
        end
        idle(5);
        check("ovf_npulse", 32'(ovf_q.size()), 32'd1);
        if (ovf_q.size() > 0) check("ovf_cycle", 32'(ovf_q[0]), 32'(t + 9));
        check("ovf_nwords", 32'(out_cyc_q.size()), 32'd0);
        check("ovf_no_skew", 32'(skew_q.size()), 32'd0);
        check("ovf_idle", 32'(busy), 32'd0);
        $display("txn overflow: pulses=%0d", ovf_q.size());

        for (int n = 0; n < 20; n++) rand_txn(n);

        // Reset pulse mid-stream, then a clean packet.
        lane_en = 4'hF;
        clear_q();
        for (int i = 0; i < 4; i++) drive(4'hF, $urandom);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        in_vld = 4'h0;
        @(negedge clk);
        check("mrst_out_vld", 32'(out_vld), 32'd0);
        check("mrst_out_data", out_data, 32'h0);
        check("mrst_errs", 32'({err_skew, err_ovf}), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        clear_q();
        drive(4'hF, 32'hA3A2A1A0);
        t = cyc;
        idle(5);
        expect_one("post_rst", t + 2, 32'hA3A2A1A0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
